// File: rtl/dmux16_pkg.sv
// Shared constants for the 16-bit two-way stream demultiplexer.
package dmux16_pkg;

    localparam int unsigned WIDTH_DEF   = 16;
    localparam int unsigned COUNT_W_DEF = 8;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage : dmux16_pkg

// File: rtl/dmux16_slot.sv
// One output port: single-entry holding register with valid/ready drain
// and a saturating count of delivered words.
module dmux16_slot
    import dmux16_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned COUNT_W = COUNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_data,
    input  logic               ready,
    input  logic               cnt_clr,
    output logic               valid,
    output logic [WIDTH-1:0]   data,
    output logic [COUNT_W-1:0] count,
    output logic               free
);

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    logic deliver;

    assign deliver = valid && ready;
    // Slot can take a word when empty or when its current word leaves this edge.
    assign free    = !valid || ready;

    // Holding register; a load on a draining edge keeps valid high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (deliver) begin
            valid <= 1'b0;
        end
    end

    // Delivered-word counter; clear takes priority over increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (cnt_clr) begin
            count <= '0;
        end else if (deliver && (count != CNT_MAX)) begin
            count <= count + COUNT_W'(1);
        end
    end

endmodule : dmux16_slot

// File: rtl/dmux16_stream.sv
// Registered 16-bit 1-to-2 stream demultiplexer: steers each accepted word
// to port a or port b, each port with its own holding slot and counter.
module dmux16_stream
    import dmux16_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned COUNT_W = COUNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   a_data,
    output logic               a_valid,
    input  logic               a_ready,
    output logic [WIDTH-1:0]   b_data,
    output logic               b_valid,
    input  logic               b_ready,
    input  logic               cnt_clr,
    output logic [COUNT_W-1:0] a_count,
    output logic [COUNT_W-1:0] b_count
);

    logic free_a;
    logic free_b;
    logic accept;
    logic load_a;
    logic load_b;

    // Readiness looks only at the selected port so a stalled port never blocks the other.
    assign in_ready = rst_n && ((in_sel == SEL_B) ? free_b : free_a);
    assign accept   = in_valid && in_ready;
    assign load_a   = accept && (in_sel == SEL_A);
    assign load_b   = accept && (in_sel == SEL_B);

    dmux16_slot #(
        .WIDTH   (WIDTH),
        .COUNT_W (COUNT_W)
    ) u_slot_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_a),
        .load_data (in_data),
        .ready     (a_ready),
        .cnt_clr   (cnt_clr),
        .valid     (a_valid),
        .data      (a_data),
        .count     (a_count),
        .free      (free_a)
    );

    dmux16_slot #(
        .WIDTH   (WIDTH),
        .COUNT_W (COUNT_W)
    ) u_slot_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_b),
        .load_data (in_data),
        .ready     (b_ready),
        .cnt_clr   (cnt_clr),
        .valid     (b_valid),
        .data      (b_data),
        .count     (b_count),
        .free      (free_b)
    );

endmodule : dmux16_stream

// File: tb/tb_dmux16_stream.sv
// Self-checking bench for dmux16_stream: a reference model of both slots
// predicts words and counts; feature tasks compare the DUT against it.
module tb_dmux16_stream;

    localparam int unsigned W    = 16;
    localparam int unsigned CW   = 4;
    localparam logic [CW-1:0] CMAX = '1;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  in_data;
    logic          in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a_data;
    logic          a_valid;
    logic          a_ready;
    logic [W-1:0]  b_data;
    logic          b_valid;
    logic          b_ready;
    logic          cnt_clr;
    logic [CW-1:0] a_count;
    logic [CW-1:0] b_count;

    int tests_run = 0;
    int fails     = 0;

    // Reference model state
    logic          mv_a = 1'b0;
    logic          mv_b = 1'b0;
    logic [CW-1:0] mc_a = '0;
    logic [CW-1:0] mc_b = '0;
    logic [W-1:0]  exp_a[$];
    logic [W-1:0]  exp_b[$];
    logic [W-1:0]  got_a[$];
    logic [W-1:0]  got_b[$];

    dmux16_stream #(
        .WIDTH   (W),
        .COUNT_W (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .cnt_clr  (cnt_clr),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: model accept/deliver from current inputs, record delivered
    // DUT words, advance the model, then land 1 time unit past the edge.
    task automatic step();
        logic er, acc, del_a, del_b;
        #3;
        er    = rst_n && (in_sel ? (!mv_b || b_ready) : (!mv_a || a_ready));
        acc   = in_valid && er;
        del_a = mv_a && a_ready;
        del_b = mv_b && b_ready;
        if (rst_n) begin
            if (del_a) got_a.push_back(a_data);
            if (del_b) got_b.push_back(b_data);
            if (acc && !in_sel) exp_a.push_back(in_data);
            if (acc &&  in_sel) exp_b.push_back(in_data);
            mv_a = (acc && !in_sel) ? 1'b1 : (del_a ? 1'b0 : mv_a);
            mv_b = (acc &&  in_sel) ? 1'b1 : (del_b ? 1'b0 : mv_b);
            mc_a = cnt_clr ? '0 : ((del_a && mc_a != CMAX) ? mc_a + CW'(1) : mc_a);
            mc_b = cnt_clr ? '0 : ((del_b && mc_b != CMAX) ? mc_b + CW'(1) : mc_b);
        end else begin
            mv_a = 1'b0;
            mv_b = 1'b0;
            mc_a = '0;
            mc_b = '0;
            exp_a.delete();
            exp_b.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h5A5A;
        a_ready = 1'b1; b_ready = 1'b1; cnt_clr = 1'b0;
        step();
        step();
        tests_run++;
        if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
            fails++; $display("FAIL reset_valid: a_valid=%b b_valid=%b, required 0 0", a_valid, b_valid);
        end
        tests_run++;
        if (a_data !== 16'h0 || b_data !== 16'h0) begin
            fails++; $display("FAIL reset_data: a_data=%h b_data=%h, required 0000 0000", a_data, b_data);
        end
        tests_run++;
        if (a_count !== '0 || b_count !== '0) begin
            fails++; $display("FAIL reset_count: a_count=%0d b_count=%0d, required 0 0", a_count, b_count);
        end
        tests_run++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL reset_in_ready: in_ready=%b, required 0", in_ready);
        end
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL release_in_ready: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_basic_steer();
        logic [W-1:0] e, g;
        a_ready = 1'b1; b_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'hFFFF;
        step();
        in_valid = 1'b0;
        tests_run++;
        if (a_valid !== 1'b1 || a_data !== 16'hFFFF || b_valid !== 1'b0) begin
            fails++; $display("FAIL steer_a: a_valid=%b a_data=%h b_valid=%b, required 1 ffff 0", a_valid, a_data, b_valid);
        end
        step();
        tests_run++;
        if (a_valid !== 1'b0 || a_count !== 4'd1) begin
            fails++; $display("FAIL steer_a_deliver: a_valid=%b a_count=%0d, required 0 1", a_valid, a_count);
        end
        in_valid = 1'b1; in_sel = 1'b1; in_data = 16'h0000;
        step();
        in_valid = 1'b0;
        tests_run++;
        if (b_valid !== 1'b1 || b_data !== 16'h0000 || a_valid !== 1'b0) begin
            fails++; $display("FAIL steer_b: b_valid=%b b_data=%h a_valid=%b, required 1 0000 0", b_valid, b_data, a_valid);
        end
        step();
        tests_run++;
        if (b_valid !== 1'b0 || b_count !== 4'd1) begin
            fails++; $display("FAIL steer_b_deliver: b_valid=%b b_count=%0d, required 0 1", b_valid, b_count);
        end
        while (exp_a.size() > 0 && got_a.size() > 0) begin
            e = exp_a.pop_front(); g = got_a.pop_front(); tests_run++;
            if (g !== e) begin fails++; $display("FAIL steer_sb_a: got %h, required %h", g, e); end
        end
        while (exp_b.size() > 0 && got_b.size() > 0) begin
            e = exp_b.pop_front(); g = got_b.pop_front(); tests_run++;
            if (g !== e) begin fails++; $display("FAIL steer_sb_b: got %h, required %h", g, e); end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] e, g;
        a_ready = 1'b0; b_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h1234;
        step();
        in_data = 16'h5555;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL bp_blocked_ready: in_ready=%b, required 0", in_ready);
        end
        step();
        tests_run++;
        if (a_valid !== 1'b1 || a_data !== 16'h1234) begin
            fails++; $display("FAIL bp_hold: a_valid=%b a_data=%h, required 1 1234", a_valid, a_data);
        end
        in_sel = 1'b1; in_data = 16'hABCD;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL bp_other_ready: in_ready=%b, required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        tests_run++;
        if (b_valid !== 1'b1 || b_data !== 16'hABCD) begin
            fails++; $display("FAIL bp_other_load: b_valid=%b b_data=%h, required 1 abcd", b_valid, b_data);
        end
        step();
        tests_run++;
        if (b_valid !== 1'b0 || b_count !== mc_b || a_valid !== 1'b1 || a_data !== 16'h1234) begin
            fails++; $display("FAIL bp_isolation: b_valid=%b b_count=%0d a_valid=%b a_data=%h, required 0 %0d 1 1234",
                              b_valid, b_count, a_valid, a_data, mc_b);
        end
        a_ready = 1'b1;
        step();
        tests_run++;
        if (a_valid !== 1'b0 || a_count !== mc_a) begin
            fails++; $display("FAIL bp_release: a_valid=%b a_count=%0d, required 0 %0d", a_valid, a_count, mc_a);
        end
        tests_run++;
        if (exp_a.size() != 1 || got_a.size() != 1 || exp_b.size() != 1 || got_b.size() != 1) begin
            fails++; $display("FAIL bp_sb_sizes: exp_a=%0d got_a=%0d exp_b=%0d got_b=%0d, required 1 each",
                              exp_a.size(), got_a.size(), exp_b.size(), got_b.size());
        end
        while (exp_a.size() > 0 && got_a.size() > 0) begin
            e = exp_a.pop_front(); g = got_a.pop_front(); tests_run++;
            if (g !== e) begin fails++; $display("FAIL bp_sb_a: got %h, required %h", g, e); end
        end
        while (exp_b.size() > 0 && got_b.size() > 0) begin
            e = exp_b.pop_front(); g = got_b.pop_front(); tests_run++;
            if (g !== e) begin fails++; $display("FAIL bp_sb_b: got %h, required %h", g, e); end
        end
    endtask

    task automatic test_streaming();
        logic [W-1:0] e, g;
        a_ready = 1'b1; b_ready = 1'b1;
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_sel = 1'b0; in_data = W'(i);
            #1;
            tests_run++;
            if (in_ready !== 1'b1) begin
                fails++; $display("FAIL stream_ready[%0d]: in_ready=%b, required 1", i, in_ready);
            end
            step();
            tests_run++;
            if (a_valid !== 1'b1 || a_data !== W'(i)) begin
                fails++; $display("FAIL stream_data[%0d]: a_valid=%b a_data=%h, required 1 %h", i, a_valid, a_data, W'(i));
            end
        end
        in_valid = 1'b0;
        step();
        tests_run++;
        if (a_count !== 4'd10 || a_valid !== 1'b0) begin
            fails++; $display("FAIL stream_count: a_count=%0d a_valid=%b, required 10 0", a_count, a_valid);
        end
        tests_run++;
        if (got_a.size() != 10) begin
            fails++; $display("FAIL stream_sb_size: got %0d words, required 10", got_a.size());
        end
        while (exp_a.size() > 0 && got_a.size() > 0) begin
            e = exp_a.pop_front(); g = got_a.pop_front(); tests_run++;
            if (g !== e) begin fails++; $display("FAIL stream_sb_a: got %h, required %h", g, e); end
        end
    endtask

    task automatic test_saturation();
        logic [W-1:0] e, g;
        a_ready = 1'b1; b_ready = 1'b1;
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_sel = 1'b1; in_data = W'(16'h0100 + i);
            step();
        end
        in_valid = 1'b0;
        step();
        tests_run++;
        if (b_count !== CMAX || a_count !== 4'd0) begin
            fails++; $display("FAIL sat_hold: b_count=%0d a_count=%0d, required %0d 0", b_count, a_count, CMAX);
        end
        in_valid = 1'b1; in_sel = 1'b1; in_data = 16'h0777;
        step();
        in_valid = 1'b0; cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        tests_run++;
        if (b_count !== 4'd0 || b_valid !== 1'b0) begin
            fails++; $display("FAIL clear_wins: b_count=%0d b_valid=%b, required 0 0", b_count, b_valid);
        end
        tests_run++;
        if (got_b.size() != 21) begin
            fails++; $display("FAIL sat_sb_size: got %0d words, required 21", got_b.size());
        end
        while (exp_b.size() > 0 && got_b.size() > 0) begin
            e = exp_b.pop_front(); g = got_b.pop_front(); tests_run++;
            if (g !== e) begin fails++; $display("FAIL sat_sb_b: got %h, required %h", g, e); end
        end
    endtask

    task automatic test_reset_mid();
        a_ready = 1'b0; b_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'hBEEF;
        step();
        in_valid = 1'b0;
        step();
        tests_run++;
        if (a_valid !== 1'b1 || a_data !== 16'hBEEF) begin
            fails++; $display("FAIL midrst_pre: a_valid=%b a_data=%h, required 1 beef", a_valid, a_data);
        end
        rst_n = 1'b0;
        step();
        tests_run++;
        if (a_valid !== 1'b0 || a_data !== 16'h0 || a_count !== 4'd0) begin
            fails++; $display("FAIL midrst_clear: a_valid=%b a_data=%h a_count=%0d, required 0 0000 0", a_valid, a_data, a_count);
        end
        rst_n = 1'b1; a_ready = 1'b1;
        step();
        step();
        tests_run++;
        if (a_valid !== 1'b0 || a_count !== 4'd0 || got_a.size() != 0) begin
            fails++; $display("FAIL midrst_no_deliver: a_valid=%b a_count=%0d delivered=%0d, required 0 0 0",
                              a_valid, a_count, got_a.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_steer();
        test_backpressure();
        test_streaming();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule : tb_dmux16_stream
